rcon_gen: RTL and testbench
===========================

# rcon_gen

Sequential, parametrised round-constant generator for the AES key-expansion datapath. It replaces a fixed 10-entry rcon lookup. It produces the rcon sequence on demand by iterating GF(2^8) xtime, and supports a runtime sequence length, which covers AES-128, AES-192 and AES-256 (10, 8 and 7 constants) and extended schedules. It also supports a reverse mode for the inverse key schedule used by the decryption and DFA key-recovery paths. It sits beside the key-expansion FSM, which requests one constant per round through a step handshake.

## Interface
Parameters:
- MAX_RCON, default 10: largest accepted sequence length; legal range 1..30.
- BYTE_LANE, default 0: byte of the 32-bit output word that carries the constant. 0 gives 32'h000000RC; 3 gives 32'hRC000000.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  one-cycle request to load a new sequence.
- dir  in  1  sampled with start. 0 = forward (01, 02, …); 1 = reverse (last constant first, down to 01).
- count_in  in  5  sequence length, sampled with start.
- step  in  1  advance to the next constant; honoured only when valid=1.
- rcon_out  out  32  current constant in byte BYTE_LANE; all other bits 0.
- index  out  5  round number of the current constant, 1-based.
- valid  out  1  rcon_out and index are meaningful.
- last  out  1  current constant is the final one of the sequence.
- done  out  1  one-cycle pulse when the sequence is exhausted.
- err  out  1  one-cycle pulse when a start is rejected.

## Operation
- States: IDLE, PREP, RUN. All outputs are registered.
- Internal state: an 8-bit register rc, a 5-bit index, a latched length cnt and a latched direction d.
- xtime(r) = {r[6:0],1'b0} ^ (r[7] ? 8'h1b : 8'h00).
- inv_xtime(y):
  - if y[0] = 1: ({1'b0,y[7:1]} ^ 8'h0d) | 8'h80;
  - else: {1'b0,y[7:1]}.
  - These are equivalent to undoing xtime.
- start with count_in = 0 or count_in > MAX_RCON:
  - ignored, err=1 for one cycle;
  - state, and any running sequence, is unchanged.
- Legal start, in any state (restart wins over step):
  - latch cnt=count_in and d=dir.
  - dir=0: go to RUN with rc=01, index=1, valid=1.
  - dir=1: go to PREP with rc=01, index=1, valid=0.
- PREP:
  - if index == cnt, go to RUN with valid=1; rc and index are held.
  - else rc=xtime(rc), index=index+1.
  - step is ignored in PREP.
- RUN, when step=1:
  - last=0 and d=0: rc=xtime(rc), index+1.
  - last=0 and d=1: rc=inv_xtime(rc), index−1.
  - last=1: go to IDLE with done=1 for one cycle and valid=0.
- last rule:
  - d=0: last = (index == cnt).
  - d=1: last = (index == 1).
  - last is only asserted while valid=1.
- Output rules:
  - rcon_out = rc placed in BYTE_LANE while valid=1; 0 otherwise.
  - index is held at its last value in IDLE.
- step outside RUN has no effect.
- rst in any state returns to IDLE with every output at its reset value.

## Timing
- Reset values: rcon_out=0, index=0, valid=0, last=0, done=0, err=0; state=IDLE.
- Forward latency: start sampled at edge T gives valid=1 with 01 after edge T.
- Reverse latency: valid=1 with the cnt-th constant after edge T+cnt. PREP lasts cnt cycles; cnt=1 means 1 PREP cycle.
- Each accepted step updates the outputs after that edge; one constant per cycle is sustainable.
- done:
  - asserted in the cycle after the step that consumed the last constant;
  - valid falls in that same cycle.
- A start in the same cycle as a final step restarts the sequence; done is not pulsed.
- err is registered and asserted the cycle after the rejected start.
- rst asserted during PREP or RUN clears everything after that edge. A start on the reset cycle is ignored.

## Test plan
- Forward, count_in=10, BYTE_LANE=0: start, then step every cycle.
  - Response: rcon_out = 01,02,04,08,10,20,40,80,1b,36 with index 1..10.
  - last=1 only on 36; done pulses one cycle after the 10th step.
- Reverse, count_in=10:
  - Response: valid rises 10 cycles after start.
  - Stepping gives 36,1b,80,40,20,10,08,04,02,01 with index 10..1; last on 01.
- Extended length, MAX_RCON=14, count_in=14:
  - Forward constants 11..14 are 6c, d8, ab, 4d.
  - Reverse first constant is 4d, then ab, d8, 6c, 36.
  - This checks the inv_xtime odd-lsb path.
- Length and lane variants:
  - count_in=8, BYTE_LANE=3: final constant 32'h80000000 with last=1.
  - count_in=7: final constant 40.
  - Irregular step gaps hold the outputs steady between steps.
- Rejects:
  - count_in=0 or count_in=MAX_RCON+1 mid-sequence gives err pulse; the sequence continues unchanged.
  - step in IDLE or PREP gives no change.
- Restart and reset:
  - start dir=1 during forward RUN at index 5 switches to PREP.
  - Synchronous rst during PREP gives all outputs 0 after the next edge.

Source files
------------

// File: rtl/rcon_gen_if.sv
// Step handshake between the key-expansion FSM (master) and the round-constant generator (slave).
interface rcon_gen_if;
   logic        start;
   logic        dir;
   logic [4:0]  count_in;
   logic        step;
   logic [31:0] rcon_out;
   logic [4:0]  index;
   logic        valid;
   logic        last;
   logic        done;
   logic        err;

   modport master (
      output start, dir, count_in, step,
      input  rcon_out, index, valid, last, done, err
   );

   modport slave (
      input  start, dir, count_in, step,
      output rcon_out, index, valid, last, done, err
   );
endinterface

// File: rtl/rcon_gen.sv
// AES round-constant generator: iterates xtime forward, or inv_xtime after a PREP walk-up in reverse mode.
module rcon_gen #(
   parameter int MAX_RCON  = 10,
   parameter int BYTE_LANE = 0
) (
   input logic       clk,
   input logic       rst,
   rcon_gen_if.slave bus
);

   typedef enum logic [1:0] {IDLE, PREP, RUN} state_t;

   localparam logic [4:0] MAX_C = 5'(MAX_RCON);

   state_t      state_q, state_d;
   logic [7:0]  rc_q, rc_d;
   logic [4:0]  idx_q, idx_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        d_q, d_d;
   logic        valid_q, valid_d;
   logic        last_q, last_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [31:0] rcon_q, rcon_d;
   logic        legal;

   function automatic logic [7:0] xtime(input logic [7:0] r);
      return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] inv_xtime(input logic [7:0] y);
      return y[0] ? (({1'b0, y[7:1]} ^ 8'h0d) | 8'h80) : {1'b0, y[7:1]};
   endfunction

   always_comb begin
      state_d = state_q;
      rc_d    = rc_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      d_d     = d_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      legal   = (bus.count_in != 5'd0) && (bus.count_in <= MAX_C);

      // A rejected start leaves everything alone; a legal one overrides any step.
      if (bus.start && !legal) begin
         err_d = 1'b1;
      end else if (bus.start) begin
         cnt_d   = bus.count_in;
         d_d     = bus.dir;
         rc_d    = 8'h01;
         idx_d   = 5'd1;
         valid_d = !bus.dir;
         state_d = bus.dir ? PREP : RUN;
      end else begin
         case (state_q)
            PREP: begin
               if (idx_q == cnt_q) begin
                  state_d = RUN;
                  valid_d = 1'b1;
               end else begin
                  rc_d  = xtime(rc_q);
                  idx_d = idx_q + 5'd1;
               end
            end
            RUN: begin
               if (bus.step) begin
                  if (last_q) begin
                     state_d = IDLE;
                     valid_d = 1'b0;
                     done_d  = 1'b1;
                  end else if (d_q) begin
                     rc_d  = inv_xtime(rc_q);
                     idx_d = idx_q - 5'd1;
                  end else begin
                     rc_d  = xtime(rc_q);
                     idx_d = idx_q + 5'd1;
                  end
               end
            end
            default: begin
            end
         endcase
      end

      // Outputs are derived from next state so they line up with it after the edge.
      last_d = valid_d && (d_d ? (idx_d == 5'd1) : (idx_d == cnt_d));
      rcon_d = valid_d ? (32'(rc_d) << (8 * BYTE_LANE)) : 32'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rc_q    <= 8'h00;
         idx_q   <= 5'd0;
         cnt_q   <= 5'd0;
         d_q     <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rcon_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         rc_q    <= rc_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         d_q     <= d_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rcon_q  <= rcon_d;
      end
   end

   assign bus.rcon_out = rcon_q;
   assign bus.index    = idx_q;
   assign bus.valid    = valid_q;
   assign bus.last     = last_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_rcon_gen.sv
// Table-driven bench for rcon_gen: dut_a (MAX_RCON=14, lane 0) and dut_b (defaults, lane 3).
module tb_rcon_gen;

   typedef struct {
      bit          sel;
      bit          rst;
      bit          start;
      bit          dir;
      logic [4:0]  cnt;
      bit          step;
      logic [31:0] rcon;
      logic [4:0]  idx;
      bit          valid;
      bit          last;
      bit          done;
      bit          err;
      string       name;
   } vec_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   vec_t vecs[$];
   logic [7:0] rc_tab [1:14];

   rcon_gen_if ifa();
   rcon_gen_if ifb();

   rcon_gen #(.MAX_RCON(14), .BYTE_LANE(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   rcon_gen #(.MAX_RCON(10), .BYTE_LANE(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] lane(input int sel, input int rc);
      logic [7:0] b;
      b = 8'(rc);
      return (sel != 0) ? {b, 24'h0} : {24'h0, b};
   endfunction

   // Expected rcon_out is zero whenever valid is expected low.
   function automatic void add(input int sel, input int r, input int st, input int dr, input int cn,
                               input int sp, input int rc, input int ix, input int v, input int l,
                               input int dn, input int er, input string nm);
      vec_t t;
      t.sel   = (sel != 0);
      t.rst   = (r != 0);
      t.start = (st != 0);
      t.dir   = (dr != 0);
      t.cnt   = 5'(cn);
      t.step  = (sp != 0);
      t.rcon  = (v != 0) ? lane(sel, rc) : 32'd0;
      t.idx   = 5'(ix);
      t.valid = (v != 0);
      t.last  = (l != 0);
      t.done  = (dn != 0);
      t.err   = (er != 0);
      t.name  = nm;
      vecs.push_back(t);
   endfunction

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic cmp(input string nm, input string sig, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s.%s got=%h want=%h", nm, sig, got, want);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      ifa.start    = v.sel ? 1'b0 : v.start;
      ifa.dir      = v.sel ? 1'b0 : v.dir;
      ifa.count_in = v.sel ? 5'd0 : v.cnt;
      ifa.step     = v.sel ? 1'b0 : v.step;
      ifb.start    = v.sel ? v.start : 1'b0;
      ifb.dir      = v.sel ? v.dir : 1'b0;
      ifb.count_in = v.sel ? v.cnt : 5'd0;
      ifb.step     = v.sel ? v.step : 1'b0;
      rst          = v.rst;
      cycle();
   endtask

   task automatic checkOutput(input vec_t v);
      logic [31:0] r;
      logic [4:0]  ix;
      logic        va, la, dn, er;
      r  = v.sel ? ifb.rcon_out : ifa.rcon_out;
      ix = v.sel ? ifb.index    : ifa.index;
      va = v.sel ? ifb.valid    : ifa.valid;
      la = v.sel ? ifb.last     : ifa.last;
      dn = v.sel ? ifb.done     : ifa.done;
      er = v.sel ? ifb.err      : ifa.err;
      cmp(v.name, "rcon_out", r, v.rcon);
      cmp(v.name, "index", 32'(ix), 32'(v.idx));
      cmp(v.name, "valid", 32'(va), 32'(v.valid));
      cmp(v.name, "last", 32'(la), 32'(v.last));
      cmp(v.name, "done", 32'(dn), 32'(v.done));
      cmp(v.name, "err", 32'(er), 32'(v.err));
   endtask

   initial begin
      int n;
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      ifa.start = 1'b0; ifa.dir = 1'b0; ifa.count_in = 5'd0; ifa.step = 1'b0;
      ifb.start = 1'b0; ifb.dir = 1'b0; ifb.count_in = 5'd0; ifb.step = 1'b0;
      rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                 8'h80, 8'h1b, 8'h36, 8'h6c, 8'hd8, 8'hab, 8'h4d};

      add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset_a");
      add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset_b");
      add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "idle_step");

      add(0, 0, 1, 0, 10, 0, 8'h01, 1, 1, 0, 0, 0, "fwd10_start");
      for (int k = 2; k <= 10; k++) add(0, 0, 0, 0, 0, 1, rc_tab[k], k, 1, int'(k == 10), 0, 0, "fwd10_step");
      add(0, 0, 0, 0, 0, 1, 0, 10, 0, 0, 1, 0, "fwd10_done");
      add(0, 0, 0, 0, 0, 1, 0, 10, 0, 0, 0, 0, "fwd10_idle");

      add(0, 0, 1, 1, 10, 0, 0, 1, 0, 0, 0, 0, "rev10_start");
      for (int j = 2; j <= 10; j++) add(0, 0, 0, 0, 0, 1, 0, j, 0, 0, 0, 0, "rev10_prep");
      add(0, 0, 0, 0, 0, 0, rc_tab[10], 10, 1, 0, 0, 0, "rev10_first");
      for (int k = 9; k >= 1; k--) add(0, 0, 0, 0, 0, 1, rc_tab[k], k, 1, int'(k == 1), 0, 0, "rev10_step");
      add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, "rev10_done");

      add(0, 0, 1, 0, 14, 0, 8'h01, 1, 1, 0, 0, 0, "fwd14_start");
      for (int k = 2; k <= 14; k++) add(0, 0, 0, 0, 0, 1, rc_tab[k], k, 1, int'(k == 14), 0, 0, "fwd14_step");
      add(0, 0, 1, 1, 14, 1, 0, 1, 0, 0, 0, 0, "restart_on_last");
      for (int j = 2; j <= 14; j++) add(0, 0, 0, 0, 0, 0, 0, j, 0, 0, 0, 0, "rev14_prep");
      add(0, 0, 0, 0, 0, 0, rc_tab[14], 14, 1, 0, 0, 0, "rev14_first");
      for (int k = 13; k >= 10; k--) add(0, 0, 0, 0, 0, 1, rc_tab[k], k, 1, 0, 0, 0, "rev14_step");
      add(0, 0, 1, 0, 0, 0, 8'h36, 10, 1, 0, 0, 1, "rej_zero");
      add(0, 0, 0, 0, 0, 0, 8'h36, 10, 1, 0, 0, 0, "rej_hold");
      add(0, 0, 1, 0, 15, 0, 8'h36, 10, 1, 0, 0, 1, "rej_15");
      add(0, 0, 0, 0, 0, 1, 8'h1b, 9, 1, 0, 0, 0, "rej_continue");

      add(0, 0, 1, 0, 10, 0, 8'h01, 1, 1, 0, 0, 0, "fwd_r_start");
      for (int k = 2; k <= 5; k++) add(0, 0, 0, 0, 0, 1, rc_tab[k], k, 1, 0, 0, 0, "fwd_r_step");
      add(0, 0, 1, 1, 3, 1, 0, 1, 0, 0, 0, 0, "restart_rev3");
      add(0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, "rev3_prep");
      add(0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0, "rev3_prep");
      add(0, 0, 0, 0, 0, 0, 8'h04, 3, 1, 0, 0, 0, "rev3_first");

      add(0, 0, 1, 1, 10, 0, 0, 1, 0, 0, 0, 0, "rst_prep_start");
      add(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, "rst_prep_walk");
      add(0, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, "rst_in_prep");
      add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "after_rst");

      add(0, 0, 1, 0, 7, 0, 8'h01, 1, 1, 0, 0, 0, "fwd7_start");
      for (int k = 2; k <= 7; k++) add(0, 0, 0, 0, 0, 1, rc_tab[k], k, 1, int'(k == 7), 0, 0, "fwd7_step");
      add(0, 0, 0, 0, 0, 1, 0, 7, 0, 0, 1, 0, "fwd7_done");

      // Lane 3 with idle gaps before every odd-numbered step.
      add(1, 0, 1, 0, 8, 0, 8'h01, 1, 1, 0, 0, 0, "b8_start");
      for (int k = 2; k <= 8; k++) begin
         if (k % 2 == 1) add(1, 0, 0, 0, 0, 0, rc_tab[k-1], k - 1, 1, 0, 0, 0, "b8_gap");
         add(1, 0, 0, 0, 0, 1, rc_tab[k], k, 1, int'(k == 8), 0, 0, "b8_step");
      end
      add(1, 0, 1, 0, 11, 0, 8'h80, 8, 1, 1, 0, 1, "b_rej_11");
      add(1, 0, 0, 0, 0, 1, 0, 8, 0, 0, 1, 0, "b8_done");

      @(negedge clk);
      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i]);
      end

      // Reverse length 1 on lane 3: exactly one PREP cycle, then the lone constant 01.
      ifb.start = 1'b1; ifb.dir = 1'b1; ifb.count_in = 5'd1;
      cycle();
      ifb.start = 1'b0; ifb.dir = 1'b0; ifb.count_in = 5'd0;
      cmp("b_rev1", "prep_valid", 32'(ifb.valid), 32'd0);
      n = 0;
      while (!ifb.valid && n < 4) begin
         cycle();
         n++;
      end
      cmp("b_rev1", "latency", 32'(n), 32'd1);
      cmp("b_rev1", "rcon_out", ifb.rcon_out, 32'h01000000);
      cmp("b_rev1", "index", 32'(ifb.index), 32'd1);
      cmp("b_rev1", "last", 32'(ifb.last), 32'd1);
      ifb.step = 1'b1;
      cycle();
      ifb.step = 1'b0;
      cmp("b_rev1", "done", 32'(ifb.done), 32'd1);
      cmp("b_rev1", "valid_after", 32'(ifb.valid), 32'd0);
      cycle();
      cmp("b_rev1", "done_pulse", 32'(ifb.done), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
